next_pc_predictor: RTL and testbench
====================================

// Module: next_pc_predictor
// PURPOSE
//  Parametrised successor of the fetch-side next-PC logic. Consumes one formalised
//  (RVC already expanded) instruction per cycle from InstFetcher and predicts the next
//  fetch PC. Branches use a BHT of saturating counters instead of static always-taken.
//  Returns (jalr ret) use a return-address stack; only non-return jalr stall.
//  Sits between the RVC expander and InstFetcher; ROB drives redirects and BHT updates.
// PARAMETERS
//  XLEN        32  address/instruction width
//  BHT_ENTRIES 64  counter count, power of 2, >=2; IDX_W=log2(BHT_ENTRIES)
//  CNT_W       2   counter width, >=1; reset value = 1<<(CNT_W-1) (weakly taken)
//  RAS_DEPTH   4   return-address-stack entries, power of 2, >=1
// PORTS
//  clk_in         in  1     system clock
//  rst_in         in  1     reset, asynchronous, active-low
//  rdy_in         in  1     low: freeze all state (outputs stay combinational)
//  _inst_ready_in in  1     _inst_in/_inst_addr valid this cycle
//  _inst_in       in  XLEN  formalised 32-bit instruction
//  _rvc_in        in  1     original was 16-bit (length 2, else 4)
//  _inst_addr     in  XLEN  PC of _inst_in
//  _br_rob        in  1     ROB mispredict redirect pulse
//  _rob_target    in  XLEN  correct PC for redirect
//  _upd_valid     in  1     ROB committed a conditional branch
//  _upd_pc        in  XLEN  PC of that branch
//  _upd_taken     in  1     its resolved direction
//  _next_pc       out XLEN  next fetch PC
//  _stall         out 1     fetch must hold until ROB redirect
//  _pred_taken    out 1     prediction tagged onto the instruction for ROB check
// BEHAVIOUR
//  Reset: all counters = weakly taken; RAS count=0, ptr=0; keep=0, jump reg=0.
//   Combinational outputs follow from that state (_stall=0 when !_inst_ready_in).
//  Decode: len = _rvc_in?2:4; branch op 1100011; jal 1101111; jalr 1100111.
//   link(r) = r==x1||r==x5. ret = jalr && rd==x0 && link(rs1) && imm==0.
//  BHT index = _inst_addr[IDX_W:1] (halfword granularity); lookup combinational.
//  _next_pc priority: keep -> jump reg; !_inst_ready_in -> _inst_addr;
//   jal -> pc+J-imm; branch -> ctr MSB ? pc+B-imm : pc+len;
//   ret && RAS non-empty -> RAS top; other jalr -> _inst_addr; else pc+len.
//  All adds modulo 2^XLEN; immediates sign-extended to XLEN.
//  _pred_taken: branch=ctr MSB, jal=1, predicted ret=1, else 0.
//  _stall = _inst_ready_in && !keep && !_br_rob && jalr && !(ret && RAS non-empty).
//  Redirect: _br_rob registers jump reg=_rob_target, keep=1 next cycle (1-cycle
//   latency); keep clears next cycle unless _br_rob again. _br_rob also flushes
//   RAS (count=0). While keep=1 the incoming instruction causes no RAS/BHT change.
//  BHT update (rdy_in && _upd_valid): saturating +1 if taken else -1 at
//   _upd_pc[IDX_W:1]; same-cycle lookup of same index sees the old value.
//  RAS (only when rdy_in, _inst_ready_in, !keep, !_br_rob):
//   jal/jalr with link(rd): push pc+len. jalr !link(rd) && link(rs1): pop.
//   jalr link(rd)&&link(rs1)&&rd!=rs1: pop then push (top replaced, count same).
//   link(rd)&&rd==rs1: push only. Push when full overwrites oldest (circular,
//   count saturates at RAS_DEPTH). Pop when empty: no-op (instruction stalls).
//  rdy_in low: no register, counter or RAS change; pending keep is held.
//  Async reset mid-operation: immediate return to reset state, any redirect lost.
// STRUCTURE
//  Shared package bpu_pkg: opcode localparams, link-register test, B/J/I immediate
//   extract functions, counter inc/dec saturate function.
//  Sub-module bpu_ras (push/pop/flush, top, empty); BHT and redirect inline.
// TESTING
//  1 Reset, branch @0x100 B-imm +16 -> _next_pc=0x110, _pred_taken=1; 2 not-taken
//    updates -> same fetch gives 0x104, _pred_taken=0; 3rd update saturates at 0.
//  2 jal x1 @0x200 (RVC) then ret @0x300 -> push 0x202; ret gives _next_pc=0x202,
//    _stall=0, RAS empty after.
//  3 ret with empty RAS -> _stall=1, _next_pc=_inst_addr; _br_rob target 0x400 ->
//    next cycle _next_pc=0x400, _stall=0.
//  4 RAS_DEPTH+1 pushes (0x10,0x20,..) then RAS_DEPTH+1 rets -> newest RAS_DEPTH
//    addresses returned in LIFO order, last ret stalls.
//  5 _upd_valid and lookup same index same cycle -> old prediction; rdy_in low
//    over _br_rob/_upd_valid -> no state change.
//  6 Assert rst_in low mid-redirect (keep=1) -> keep=0, counters weakly taken at once.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared decode and counter helpers for the next-PC predictor.
//   OPC_*        RV32 opcodes of the control-transfer instructions
//   inst_kind_e  coarse classification of a formalised instruction
//   is_link      rd/rs1 is a link register (x1 or x5)
//   imm_b/j/i    sign-extended 32-bit immediates
//   ctr_sat      saturating up/down step of a CNT_W-bit counter
package bpu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        InstOther,
        InstBranch,
        InstJal,
        InstJalr
    } inst_kind_e;

    function automatic inst_kind_e decode_kind(input logic [6:0] opcode);
        case (opcode)
            OPC_BRANCH: return InstBranch;
            OPC_JAL:    return InstJal;
            OPC_JALR:   return InstJalr;
            default:    return InstOther;
        endcase
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // Counter value travels as a 32-bit unsigned so one function serves any CNT_W.
    function automatic int unsigned ctr_sat(input int unsigned ctr, input logic taken,
                                            input int unsigned width);
        int unsigned max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack.
//   clk_in, rst_in  clock, asynchronous active-low reset
//   flush           discard all entries (wins over push/pop)
//   push, pop       both together replace the top entry in place
//   push_data       return address to push
//   top             newest entry (undefined content when empty)
//   empty           no valid entries
// Pushing when full overwrites the oldest entry; popping when empty does nothing.
module bpu_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    import bpu_pkg::*;

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;     // next free slot
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] ptr_top;
    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        ptr_top = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;
        ptr_nxt = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    assign empty = (count_q == '0);
    assign top   = stack_q[ptr_top];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else if (flush) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push && pop && !empty) begin
            stack_q[ptr_top] <= push_data;
        end else if (push) begin
            stack_q[ptr_q] <= push_data;
            ptr_q          <= ptr_nxt;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_q   <= ptr_top;
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-side next-PC predictor: BHT of saturating counters for branches, RAS for
// returns, registered ROB redirect.
//   clk_in, rst_in        clock, asynchronous active-low reset
//   rdy_in                low freezes all state
//   _inst_ready_in        _inst_in/_inst_addr valid
//   _inst_in, _rvc_in     formalised instruction, original was 16-bit
//   _inst_addr            PC of _inst_in
//   _br_rob, _rob_target  mispredict redirect and its target
//   _upd_valid/_pc/_taken committed branch outcome for the BHT
//   _next_pc              next fetch PC
//   _stall                fetch must wait for a ROB redirect
//   _pred_taken           prediction tagged onto the instruction
module next_pc_predictor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            _inst_ready_in,
    input  logic [XLEN-1:0] _inst_in,
    input  logic            _rvc_in,
    input  logic [XLEN-1:0] _inst_addr,
    input  logic            _br_rob,
    input  logic [XLEN-1:0] _rob_target,
    input  logic            _upd_valid,
    input  logic [XLEN-1:0] _upd_pc,
    input  logic            _upd_taken,
    output logic [XLEN-1:0] _next_pc,
    output logic            _stall,
    output logic            _pred_taken
);
    import bpu_pkg::*;

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(1) << (CNT_W - 1);

    logic [CNT_W-1:0] bht_q [BHT_ENTRIES];
    logic             keep_q;
    logic [XLEN-1:0]  jump_q;

    logic [31:0]      inst32;
    inst_kind_e       kind;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic             is_ret;
    logic [XLEN-1:0]  len;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             bht_taken;
    logic             ras_ok;
    logic             ras_push;
    logic             ras_pop;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;

    assign inst32     = _inst_in[31:0];
    assign kind       = decode_kind(inst32[6:0]);
    assign rd         = inst32[11:7];
    assign rs1        = inst32[19:15];
    assign is_ret     = (kind == InstJalr) && (rd == 5'd0) && is_link(rs1)
                        && (inst32[31:20] == 12'd0);
    assign len        = _rvc_in ? XLEN'(2) : XLEN'(4);
    assign lookup_idx = _inst_addr[IDX_W:1];
    assign upd_idx    = _upd_pc[IDX_W:1];
    assign bht_taken  = bht_q[lookup_idx][CNT_W-1];

    // Instructions seen during a pending redirect are on the wrong path.
    assign ras_ok   = rdy_in && _inst_ready_in && !keep_q && !_br_rob;
    assign ras_push = ras_ok && ((kind == InstJal) || (kind == InstJalr)) && is_link(rd);
    assign ras_pop  = ras_ok && (kind == InstJalr) && is_link(rs1)
                      && (!is_link(rd) || (rd != rs1));

    bpu_ras #(
        .XLEN     (XLEN),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (rdy_in && _br_rob),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(_inst_addr + len),
        .top      (ras_top),
        .empty    (ras_empty)
    );

    always_comb begin
        _next_pc    = _inst_addr + len;
        _pred_taken = 1'b0;
        if (keep_q) begin
            _next_pc = jump_q;
        end else if (!_inst_ready_in) begin
            _next_pc = _inst_addr;
        end else begin
            case (kind)
                InstJal: begin
                    _next_pc = _inst_addr + XLEN'($signed(imm_j(inst32)));
                end
                InstBranch: begin
                    if (bht_taken) begin
                        _next_pc = _inst_addr + XLEN'($signed(imm_b(inst32)));
                    end
                end
                InstJalr: begin
                    // Non-return jalr has no target yet; fetch holds on its own PC.
                    _next_pc = (is_ret && !ras_empty) ? ras_top : _inst_addr;
                end
                default: ;
            endcase
        end
        case (kind)
            InstBranch: _pred_taken = bht_taken;
            InstJal:    _pred_taken = 1'b1;
            InstJalr:   _pred_taken = is_ret && !ras_empty;
            default:    _pred_taken = 1'b0;
        endcase
    end

    assign _stall = _inst_ready_in && !keep_q && !_br_rob && (kind == InstJalr)
                    && !(is_ret && !ras_empty);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            keep_q <= 1'b0;
            jump_q <= '0;
        end else if (rdy_in) begin
            keep_q <= _br_rob;
            if (_br_rob) begin
                jump_q <= _rob_target;
            end
        end
    end

    // Lookup reads the registered array, so a same-cycle update is not visible.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else if (rdy_in && _upd_valid) begin
            bht_q[upd_idx] <= CNT_W'(ctr_sat(32'(bht_q[upd_idx]), _upd_taken, CNT_W));
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;

    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in;
    logic        rst_in;
    logic        rdy;
    logic        inst_ready;
    logic [31:0] inst;
    logic        rvc;
    logic [31:0] inst_addr;
    logic        br_rob;
    logic [31:0] rob_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] next_pc;
    logic        stall;
    logic        pred_taken;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        stall;
        logic        pred;
    } sample_t;

    sample_t exp_q[$];
    sample_t obs_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    next_pc_predictor #(
        .XLEN       (32),
        .BHT_ENTRIES(64),
        .CNT_W      (2),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy),
        ._inst_ready_in(inst_ready),
        ._inst_in      (inst),
        ._rvc_in       (rvc),
        ._inst_addr    (inst_addr),
        ._br_rob       (br_rob),
        ._rob_target   (rob_target),
        ._upd_valid    (upd_valid),
        ._upd_pc       (upd_pc),
        ._upd_taken    (upd_taken),
        ._next_pc      (next_pc),
        ._stall        (stall),
        ._pred_taken   (pred_taken)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    // One clocked cycle of stimulus; expected result queued now, DUT result queued at negedge.
    task automatic drive(input string nm, input logic r, input logic ird, input logic [31:0] ins,
                         input logic c, input logic [31:0] addr, input logic br,
                         input logic [31:0] tgt, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] e_pc, input logic e_stall,
                         input logic e_pred);
        sample_t e;
        sample_t o;
        @(posedge clk_in);
        #1;
        rdy = r; inst_ready = ird; inst = ins; rvc = c; inst_addr = addr;
        br_rob = br; rob_target = tgt; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        e.name = nm; e.pc = e_pc; e.stall = e_stall; e.pred = e_pred;
        exp_q.push_back(e);
        @(negedge clk_in);
        o.name = nm; o.pc = next_pc; o.stall = stall; o.pred = pred_taken;
        obs_q.push_back(o);
    endtask

    task automatic fetch(input string nm, input logic [31:0] ins, input logic c,
                         input logic [31:0] addr, input logic [31:0] e_pc,
                         input logic e_stall, input logic e_pred);
        drive(nm, 1'b1, 1'b1, ins, c, addr, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              e_pc, e_stall, e_pred);
    endtask

    task automatic upd(input string nm, input logic [31:0] pc, input logic tk);
        drive(nm, 1'b1, 1'b0, NOP, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, pc, tk, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        sample_t e;
        sample_t o;
        drive("reset_idle", 1'b1, 1'b0, NOP, 1'b0, 32'h1234, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              32'h1234, 1'b0, 1'b0);
        fetch("reset_ret_empty", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h40, 32'h40, 1'b1, 1'b0);
        fetch("reset_weak_taken", enc_b(13'd16), 1'b0, 32'h100, 32'h110, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_bht;
        sample_t e;
        sample_t o;
        upd("bht_dn1", 32'h100, 1'b0);
        upd("bht_dn2", 32'h100, 1'b0);
        fetch("bht_not_taken", enc_b(13'd16), 1'b0, 32'h100, 32'h104, 1'b0, 1'b0);
        upd("bht_dn3_sat", 32'h100, 1'b0);
        upd("bht_up1", 32'h100, 1'b1);
        fetch("bht_after_up1", enc_b(13'd16), 1'b0, 32'h100, 32'h104, 1'b0, 1'b0);
        upd("bht_up2", 32'h100, 1'b1);
        fetch("bht_after_up2", enc_b(13'd16), 1'b0, 32'h100, 32'h110, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_call_ret;
        sample_t e;
        sample_t o;
        fetch("jal_rvc", enc_jal(5'd1, 21'h100), 1'b1, 32'h200, 32'h300, 1'b0, 1'b1);
        fetch("ret_hit", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h300, 32'h202, 1'b0, 1'b1);
        fetch("ret_now_empty", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h304, 32'h304, 1'b1, 1'b0);
        fetch("jal_rvc_again", enc_jal(5'd1, 21'h100), 1'b1, 32'h200, 32'h300, 1'b0, 1'b1);
        fetch("jalr_replace", enc_jalr(5'd5, 5'd1, 12'd0), 1'b0, 32'h210, 32'h210, 1'b1, 1'b0);
        fetch("ret_replaced", enc_jalr(5'd0, 5'd5, 12'd0), 1'b0, 32'h310, 32'h214, 1'b0, 1'b1);
        fetch("ret_after_repl", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h314, 32'h314, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_redirect;
        sample_t e;
        sample_t o;
        fetch("stall_ret", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h500, 32'h500, 1'b1, 1'b0);
        drive("redirect_cycle", 1'b1, 1'b1, enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h500,
              1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 32'h500, 1'b0, 1'b0);
        fetch("keep_target", enc_jal(5'd1, 21'h40), 1'b0, 32'h600, 32'h400, 1'b0, 1'b1);
        fetch("no_push_in_keep", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h400, 32'h400,
              1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_ras_overflow;
        sample_t     e;
        sample_t     o;
        logic [31:0] model[$];
        logic [31:0] pc;
        for (int i = 0; i <= int'(RAS_DEPTH); i++) begin
            pc = 32'h0C + 32'h10 * 32'(i);
            if (model.size() == int'(RAS_DEPTH)) begin
                void'(model.pop_front());
            end
            model.push_back(pc + 32'd4);
            fetch($sformatf("ovf_push%0d", i), enc_jal(5'd1, 21'd8), 1'b0, pc, pc + 32'd8,
                  1'b0, 1'b1);
        end
        for (int i = 0; i <= int'(RAS_DEPTH); i++) begin
            pc = 32'h700 + 32'd4 * 32'(i);
            if (model.size() > 0) begin
                fetch($sformatf("ovf_ret%0d", i), enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, pc,
                      model.pop_back(), 1'b0, 1'b1);
            end else begin
                fetch($sformatf("ovf_ret%0d", i), enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, pc,
                      pc, 1'b1, 1'b0);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_same_cycle_and_freeze;
        sample_t e;
        sample_t o;
        fetch("frz_push", enc_jal(5'd1, 21'd8), 1'b0, 32'h80, 32'h88, 1'b0, 1'b1);
        drive("upd_same_idx", 1'b1, 1'b1, enc_b(13'd16), 1'b0, 32'h100, 1'b0, 32'd0,
              1'b1, 32'h100, 1'b0, 32'h110, 1'b0, 1'b1);
        fetch("upd_visible", enc_b(13'd16), 1'b0, 32'h100, 32'h104, 1'b0, 1'b0);
        drive("frozen_cycle", 1'b0, 1'b1, enc_b(13'd16), 1'b0, 32'h100, 1'b1, 32'h900,
              1'b1, 32'h100, 1'b1, 32'h104, 1'b0, 1'b0);
        fetch("frz_no_keep_no_upd", enc_b(13'd16), 1'b0, 32'h100, 32'h104, 1'b0, 1'b0);
        fetch("frz_ras_kept", enc_jalr(5'd0, 5'd1, 12'd0), 1'b0, 32'h310, 32'h84, 1'b0, 1'b1);
        drive("hold_redirect", 1'b1, 1'b0, NOP, 1'b0, 32'h50, 1'b1, 32'hA00, 1'b0, 32'd0, 1'b0,
              32'h50, 1'b0, 1'b0);
        drive("hold_keep1", 1'b0, 1'b0, NOP, 1'b0, 32'h50, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              32'hA00, 1'b0, 1'b0);
        drive("hold_keep2", 1'b0, 1'b0, NOP, 1'b0, 32'h50, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              32'hA00, 1'b0, 1'b0);
        drive("hold_keep3", 1'b1, 1'b0, NOP, 1'b0, 32'h50, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              32'hA00, 1'b0, 1'b0);
        drive("hold_cleared", 1'b1, 1'b0, NOP, 1'b0, 32'h50, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0,
              32'h50, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.pc !== e.pc || o.stall !== e.stall || o.pred !== e.pred) begin
                n_fail++;
                $display("FAIL %s: got pc=%h stall=%b pred=%b, want pc=%h stall=%b pred=%b",
                         e.name, o.pc, o.stall, o.pred, e.pc, e.stall, e.pred);
            end
        end
    endtask

    task automatic test_async_reset;
        // BHT entry for 0x100 sits at 1 (not taken) before this task.
        drive("pre_rst_redirect", 1'b1, 1'b0, NOP, 1'b0, 32'h60, 1'b1, 32'hB00, 1'b0, 32'd0,
              1'b0, 32'h60, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        void'(obs_q.pop_front());
        @(posedge clk_in);
        #1;
        br_rob = 1'b0;
        #1;
        n_checks++;
        if (next_pc !== 32'hB00) begin
            n_fail++;
            $display("FAIL rst_keep_set: got pc=%h, want pc=%h", next_pc, 32'hB00);
        end
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (next_pc !== 32'h60) begin
            n_fail++;
            $display("FAIL rst_keep_cleared: got pc=%h, want pc=%h", next_pc, 32'h60);
        end
        inst_ready = 1'b1;
        inst       = enc_b(13'd16);
        inst_addr  = 32'h100;
        #1;
        n_checks++;
        if (next_pc !== 32'h110 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ctr_weak: got pc=%h pred=%b, want pc=%h pred=1",
                     next_pc, pred_taken, 32'h110);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in = 1'b0; rdy = 1'b1; inst_ready = 1'b0; inst = NOP; rvc = 1'b0;
        inst_addr = 32'd0; br_rob = 1'b0; rob_target = 32'd0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        test_reset();
        test_bht();
        test_call_ret();
        test_redirect();
        test_ras_overflow();
        test_same_cycle_and_freeze();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
